// File: rtl/alu_pkg.sv
// Shared ALU control codes, mul/div operation codes and sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FAST = 2'b10,
        ST_DONE = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU shared with the execute stage; Zero flags an all-zero result.
module alu #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   alu_cntrl,
    output logic [W-1:0] result,
    output logic         zero
);
    import alu_pkg::*;

    always_comb begin
        result = '0;
        case (alu_cntrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer: one WIDTH+1 ALU driven for WIDTH cycles of
// shift-add or restoring shift-subtract; divide-by-zero and reserved ops take a short path.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    muldiv_op_e       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   alu_x, alu_y, alu_res;
    logic [3:0]       alu_ctrl;
    logic             alu_zero_unused;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] final_val;
    logic             is_div;
    logic             take_fast;

    // Q shifts its top bit into R each step; Q ends up holding the quotient.
    assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);

    always_comb begin
        alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
        alu_x    = is_div ? {1'b0, rem_shift} : {1'b0, acc_q};
        alu_y    = is_div ? {1'b0, dvsr_q}    : {1'b0, mcand_q};
    end

    alu #(.W(WIDTH + 1)) u_alu (
        .a         (alu_x),
        .b         (alu_y),
        .alu_cntrl (alu_ctrl),
        .result    (alu_res),
        .zero      (alu_zero_unused)
    );

    always_comb begin
        final_val = '0;
        case (op_q)
            OP_MUL:  final_val = acc_q;
            OP_DIVU: final_val = quo_q;
            OP_REMU: final_val = rem_q;
            default: final_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        res_d     = res_q;
        dbz_d     = dbz_q;
        take_fast = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d      = muldiv_op_e'(op);
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = a;
                    mplier_d  = b;
                    quo_d     = a;
                    rem_d     = '0;
                    dvsr_d    = b;
                    dbz_d     = ((op_d == OP_DIVU) || (op_d == OP_REMU)) && (b == '0);
                    take_fast = (op_d == OP_RSVD) || dbz_d;
                    state_d   = take_fast ? ST_FAST : ST_RUN;
                end
            end
            ST_RUN: begin
                if (is_div) begin
                    // A borrow out of bit WIDTH means R' < divisor: restore.
                    if (!alu_res[WIDTH]) begin
                        rem_d = alu_res[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = alu_res[WIDTH-1:0];
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_FAST: begin
                // Quotient all ones, remainder is the dividend (still held in Q).
                if (dbz_q) begin
                    quo_d = '1;
                    rem_d = quo_q;
                end else begin
                    acc_d = '0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_d   = final_val;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            res_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            res_q    <= res_d;
            dbz_q    <= dbz_d;
        end
    end

    // The finished value is visible during DONE itself; a flush in DONE suppresses it.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE) && !flush;
    assign result      = done ? final_val : res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomized checks of the iterative MUL/DIVU/REMU sequencer against
// an arithmetic reference model.
module tb_alu_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] last_result;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [2*W-1:0] p;
        case (o)
            2'd0: begin
                p = (2*W)'(x) * (2*W)'(y);
                return p[W-1:0];
            end
            2'd1:    return (y == '0) ? '1 : x / y;
            2'd2:    return (y == '0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally pulse a competing start at cycle inject_at, and check it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inject_at);
        logic [W-1:0] exp_res;
        logic         exp_dbz;
        int           exp_lat;
        int           n;
        logic         busy_all;
        exp_res = model(o, x, y);
        exp_dbz = ((o == 2'd1) || (o == 2'd2)) && (y == '0);
        exp_lat = ((o == 2'd3) || exp_dbz) ? 2 : W + 1;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 1;
        busy_all = busy;
        while (!done && n < 200) begin
            start = (n == inject_at);
            @(posedge clk); #1;
            n++;
            busy_all &= busy;
        end
        start = 1'b0;
        check({tag, "_latency"}, W'(n), W'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_dbz"}, W'(div_by_zero), W'(exp_dbz));
        check({tag, "_busy_held"}, W'(busy_all), W'(1));
        last_result = exp_res;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, W'(done), W'(0));
        check({tag, "_idle"}, W'(busy), W'(0));
        check({tag, "_res_hold"}, result, exp_res);
    endtask

    task automatic run_flush(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input int at);
        int   n;
        logic seen_done;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        seen_done = 1'b0;
        while (n < at) begin
            @(posedge clk); #1;
            n++;
            seen_done |= done;
        end
        flush = 1'b1;
        #1 seen_done |= done;
        @(posedge clk); #1;
        flush = 1'b0;
        check({tag, "_busy_after"}, W'(busy), W'(0));
        check({tag, "_res_kept"}, result, last_result);
        repeat (40) begin
            @(posedge clk); #1;
            seen_done |= done;
        end
        check({tag, "_no_done"}, W'(seen_done), W'(0));
        check({tag, "_res_still"}, result, last_result);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        last_result = '0;
        #12;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, -1);
        run_op("mul_ffx2", 2'd0, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("mul_x0", 2'd0, 32'h1234_5678, 32'd0, -1);
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7, -1);
        run_op("remu_100_7", 2'd2, 32'd100, 32'd7, -1);
        run_op("divu_ff_1", 2'd1, 32'hFFFF_FFFF, 32'd1, -1);
        run_op("remu_3_10", 2'd2, 32'd3, 32'd10, -1);
        run_op("divu_5_0", 2'd1, 32'd5, 32'd0, -1);
        run_op("remu_5_0", 2'd2, 32'd5, 32'd0, -1);
        run_op("rsvd", 2'd3, 32'hDEAD_BEEF, 32'd9, -1);
        run_op("mul_inject", 2'd0, 32'd1234, 32'd5678, 10);

        // start together with flush in IDLE must not launch anything
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("idle_flush_busy", W'(busy), W'(0));
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("idle_flush_busy2", W'(busy), W'(0));
        check("idle_flush_res", result, last_result);

        run_flush("flush_divu", 2'd1, 32'd1000, 32'd3, 15);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd99; b = 32'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_result", result, '0);
        @(negedge clk);
        rst = 1'b0;
        last_result = '0;
        run_op("after_rst", 2'd1, 32'd1000, 32'd33, -1);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
            run_op($sformatf("rand%0d", i), ro, ra, rb, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
